// File: rtl/bcedn_frame_sched_pkg.sv
// Shared types and default sizing for the encoder/decoder frame scheduler.
package bcedn_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_GAP   = 2'd3
  } sched_state_e;

  // EC_4 configuration: one frame is 1024 words in and 1024 words out.
  localparam int EC4_IN_BEATS  = 1024;
  localparam int EC4_OUT_BEATS = 1024;
  localparam int BUS_W         = 512;

  // Width needed to hold values 0..max_val inclusive.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bcedn_frame_sched_if.sv
// Handshake bundle between host, input FIFO, engine and the frame scheduler.
interface bcedn_frame_sched_if;

  logic frame_req;
  logic frame_ack;
  logic host_in_valid;
  logic host_in_ready;
  logic fifo_wfull;
  logic fifo_winc;
  logic eng_start;
  logic eng_done;
  logic eng_out_en;

  modport master (
    output frame_req, host_in_valid, fifo_wfull, eng_done, eng_out_en,
    input  frame_ack, host_in_ready, fifo_winc, eng_start
  );

  modport slave (
    input  frame_req, host_in_valid, fifo_wfull, eng_done, eng_out_en,
    output frame_ack, host_in_ready, fifo_winc, eng_start
  );

endinterface

// File: rtl/bcedn_frame_sched_beat_counter.sv
// Saturating beat counter: synchronous clear, count enable, stops at limit and flags it.
module bcedn_beat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             hit
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  assign hit = (cnt_q == limit);
  assign cnt = cnt_q;

  // Next count: clear wins, otherwise step only while below the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (en && !hit) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bcedn_frame_sched.sv
// Frame scheduler for the encoder/decoder stage: one frame in flight, gated FIFO writes, idle gap.
// Optional stall watchdog enabled by defining BCEDN_FRAME_SCHED_WATCHDOG_EN.
module bcedn_frame_sched
  import bcedn_sched_pkg::*;
#(
  parameter int IN_BEATS  = EC4_IN_BEATS,
  parameter int OUT_BEATS = EC4_OUT_BEATS,
  parameter int CNT_W     = 16,
  parameter int GAP_CYC   = 4,
  parameter int FRM_W     = 16,
  parameter int TIMEOUT   = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  bcedn_frame_sched_if.slave   bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     in_cnt,
  output logic [CNT_W-1:0]     out_cnt,
  output logic [FRM_W-1:0]     frame_cnt,
  output logic                 err_overrun,
  output logic                 err_timeout
);

  localparam int GAP_W = cnt_width(GAP_CYC);

  sched_state_e      state_d, state_q;
  logic              frame_ack_d, frame_ack_q;
  logic              eng_start_d, eng_start_q;
  logic              done_seen_d, done_seen_q;
  logic [GAP_W-1:0]  gap_d, gap_q;
  logic [FRM_W-1:0]  frame_cnt_d, frame_cnt_q;
  logic              err_overrun_d, err_overrun_q;
  logic              err_timeout_d, err_timeout_q;

  logic              run_s;
  logic              cnt_clr_s;
  logic              fifo_winc_s;
  logic              out_en_s;
  logic              in_hit_s;
  logic              out_hit_s;
  logic              frame_done_s;
  logic              wd_fire_s;

  assign run_s        = (state_q == ST_RUN);
  assign fifo_winc_s  = run_s & bus.host_in_valid & ~bus.fifo_wfull & ~in_hit_s;
  assign out_en_s     = run_s & bus.eng_out_en;
  assign frame_done_s = in_hit_s & out_hit_s & done_seen_q;

  bcedn_beat_counter #(.CNT_W(CNT_W)) u_in_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr_s),
    .en    (fifo_winc_s),
    .limit (CNT_W'(IN_BEATS)),
    .cnt   (in_cnt),
    .hit   (in_hit_s)
  );

  bcedn_beat_counter #(.CNT_W(CNT_W)) u_out_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr_s),
    .en    (out_en_s),
    .limit (CNT_W'(OUT_BEATS)),
    .cnt   (out_cnt),
    .hit   (out_hit_s)
  );

`ifdef BCEDN_FRAME_SCHED_WATCHDOG_EN
  localparam int STALL_W = cnt_width(TIMEOUT);

  logic [STALL_W-1:0] stall_d, stall_q;
  logic               activity_s;

  assign activity_s = fifo_winc_s | bus.eng_out_en | bus.eng_done;

  // Stall counter runs only in RUN and restarts on any frame progress.
  always_comb begin
    stall_d   = {STALL_W{1'b0}};
    wd_fire_s = 1'b0;
    if (run_s && !activity_s) begin
      if (stall_q == STALL_W'(TIMEOUT - 1)) begin
        wd_fire_s = 1'b1;
      end else begin
        stall_d = stall_q + {{(STALL_W-1){1'b0}}, 1'b1};
      end
    end else begin
      stall_d = {STALL_W{1'b0}};
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= {STALL_W{1'b0}};
    end else begin
      stall_q <= stall_d;
    end
  end

  assign err_timeout_d = err_timeout_q | wd_fire_s;
`else
  localparam int unused_timeout = TIMEOUT;

  assign wd_fire_s     = 1'b0;
  assign err_timeout_d = 1'b0;
`endif

  // Sequencer next state, one-cycle pulses, gap timing and sticky overrun.
  always_comb begin
    state_d       = state_q;
    frame_ack_d   = 1'b0;
    eng_start_d   = 1'b0;
    done_seen_d   = done_seen_q;
    gap_d         = gap_q;
    frame_cnt_d   = frame_cnt_q;
    cnt_clr_s     = 1'b0;
    err_overrun_d = err_overrun_q | (bus.eng_out_en & (~run_s | out_hit_s));
    unique case (state_q)
      ST_IDLE: begin
        if (bus.frame_req) begin
          state_d     = ST_START;
          frame_ack_d = 1'b1;
          cnt_clr_s   = 1'b1;
          done_seen_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        state_d     = ST_RUN;
        eng_start_d = 1'b1;
        done_seen_d = done_seen_q | bus.eng_done;
      end
      ST_RUN: begin
        done_seen_d = done_seen_q | bus.eng_done;
        gap_d       = {GAP_W{1'b0}};
        if (frame_done_s) begin
          state_d     = ST_GAP;
          frame_cnt_d = frame_cnt_q + {{(FRM_W-1){1'b0}}, 1'b1};
        end else if (wd_fire_s) begin
          state_d = ST_GAP;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(GAP_CYC - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + {{(GAP_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer, status and error registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      frame_ack_q   <= 1'b0;
      eng_start_q   <= 1'b0;
      done_seen_q   <= 1'b0;
      gap_q         <= {GAP_W{1'b0}};
      frame_cnt_q   <= {FRM_W{1'b0}};
      err_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_ack_q   <= frame_ack_d;
      eng_start_q   <= eng_start_d;
      done_seen_q   <= done_seen_d;
      gap_q         <= gap_d;
      frame_cnt_q   <= frame_cnt_d;
      err_overrun_q <= err_overrun_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign bus.frame_ack     = frame_ack_q;
  assign bus.eng_start     = eng_start_q;
  assign bus.fifo_winc     = fifo_winc_s;
  assign bus.host_in_ready = fifo_winc_s;
  assign busy              = (state_q != ST_IDLE);
  assign frame_cnt         = frame_cnt_q;
  assign err_overrun       = err_overrun_q;
  assign err_timeout       = err_timeout_q;

endmodule

// File: tb/tb_bcedn_frame_sched.sv
// Directed bench for bcedn_frame_sched with 8-beat frames, 4-cycle gap and a 16-cycle watchdog.
module tb_bcedn_frame_sched;

  localparam int CNT_W = 16;
  localparam int FRM_W = 16;

  logic clk;
  logic rst;
  logic busy;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic [FRM_W-1:0] frame_cnt;
  logic err_overrun;
  logic err_timeout;

  int checks = 0;
  int errors = 0;

  bcedn_frame_sched_if bus();

  bcedn_frame_sched #(
    .IN_BEATS(8), .OUT_BEATS(8), .CNT_W(CNT_W), .GAP_CYC(4), .FRM_W(FRM_W), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .in_cnt(in_cnt), .out_cnt(out_cnt),
    .frame_cnt(frame_cnt), .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic req, valid, wfull, done, oen;
    logic ack, start, winc, busy;
    int   in_c, out_c, frm;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs after the falling edge, settle, leave outputs for sampling.
  task automatic cyc(input logic req, input logic valid, input logic wfull,
                     input logic done, input logic oen);
    @(negedge clk);
    bus.frame_req     = req;
    bus.host_in_valid = valid;
    bus.fifo_wfull    = wfull;
    bus.eng_done      = done;
    bus.eng_out_en    = oen;
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("idle_wait", busy, 0);
  endtask

  task automatic run_frame(input int done_cyc);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 9; c++)
      cyc(1'b0, c >= 2, 1'b0, c == done_cyc, c >= 2);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    bus.frame_req = 1'b0; bus.host_in_valid = 1'b0; bus.fifo_wfull = 1'b0;
    bus.eng_done = 1'b0; bus.eng_out_en = 1'b0;
    rst = 1'b0;

    // Nominal frame; host_in_valid held 12 cycles, done with the 8th beat.
    tbl[0]  = '{1,0,0,0,0, 0,0,0,0, 0,0,0};
    tbl[1]  = '{0,0,0,0,0, 1,0,0,1, 0,0,0};
    for (int c = 2; c <= 9; c++)
      tbl[c] = '{0,1,0,(c == 9),1, 0,(c == 2),1,1, c-2,c-2,0};
    tbl[10] = '{0,1,0,0,0, 0,0,0,1, 8,8,0};
    tbl[11] = '{0,1,0,0,0, 0,0,0,1, 8,8,1};
    tbl[12] = '{0,1,0,0,0, 0,0,0,1, 8,8,1};
    tbl[13] = '{0,1,0,0,0, 0,0,0,1, 8,8,1};
    tbl[14] = '{0,0,0,0,0, 0,0,0,1, 8,8,1};
    tbl[15] = '{0,0,0,0,0, 0,0,0,0, 8,8,1};

    #23;
    chk("rst_busy", busy, 0);
    chk("rst_ack", bus.frame_ack, 0);
    chk("rst_start", bus.eng_start, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].req, tbl[i].valid, tbl[i].wfull, tbl[i].done, tbl[i].oen);
      chk($sformatf("nom%0d_ack", i), bus.frame_ack, tbl[i].ack);
      chk($sformatf("nom%0d_start", i), bus.eng_start, tbl[i].start);
      chk($sformatf("nom%0d_winc", i), bus.fifo_winc, tbl[i].winc);
      chk($sformatf("nom%0d_ready", i), bus.host_in_ready, tbl[i].winc);
      chk($sformatf("nom%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("nom%0d_in_cnt", i), in_cnt, tbl[i].in_c);
      chk($sformatf("nom%0d_out_cnt", i), out_cnt, tbl[i].out_c);
      chk($sformatf("nom%0d_frame_cnt", i), frame_cnt, tbl[i].frm);
      chk($sformatf("nom%0d_overrun", i), err_overrun, 0);
    end

    // Backpressure: FIFO almost-full during cycles 5-9.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      cyc(1'b0, c >= 2, (c >= 5 && c <= 9), c == 10, (c >= 2 && c <= 9));
      if (c >= 5 && c <= 9) begin
        chk($sformatf("bp%0d_winc", c), bus.fifo_winc, 0);
        chk($sformatf("bp%0d_in_cnt", c), in_cnt, 3);
      end
    end
    wait_idle();
    chk("bp_in_cnt_final", in_cnt, 8);
    chk("bp_frame_cnt", frame_cnt, 2);

    // Completion pulse arriving while still in START must be remembered.
    run_frame(1);
    chk("done_in_start_frame_cnt", frame_cnt, 3);
    chk("done_in_start_overrun", err_overrun, 0);

    // Result overrun: a 9th eng_out_en beat in RUN.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 10; c++)
      cyc(1'b0, (c >= 2 && c <= 9), 1'b0, c == 9, c >= 2);
    chk("ovr_before", err_overrun, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("ovr_set", err_overrun, 1);
    chk("ovr_out_cnt", out_cnt, 8);
    wait_idle();
    chk("ovr_frame_cnt", frame_cnt, 4);
    chk("ovr_sticky", err_overrun, 1);

    // Asynchronous reset in RUN with three words accepted.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c <= 5; c++)
      cyc(1'b0, c >= 2, 1'b0, 1'b0, 1'b0);
    chk("arst_pre_in_cnt", in_cnt, 3);
    rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_in_cnt", in_cnt, 0);
    chk("arst_winc", bus.fifo_winc, 0);
    chk("arst_frame_cnt", frame_cnt, 0);
    chk("arst_overrun", err_overrun, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    run_frame(9);
    chk("post_rst_frame_cnt", frame_cnt, 1);
    chk("post_rst_in_cnt", in_cnt, 8);
    chk("post_rst_out_cnt", out_cnt, 8);

`ifdef BCEDN_FRAME_SCHED_WATCHDOG_EN
    // Watchdog: no progress after the start pulse.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wd_not_yet", err_timeout, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wd_set", err_timeout, 1);
    chk("wd_in_gap_busy", busy, 1);
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wd_gap_end_busy", busy, 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("wd_idle", busy, 0);
    chk("wd_frame_cnt", frame_cnt, 1);
    chk("wd_sticky", err_timeout, 1);
`else
    chk("no_wd_timeout", err_timeout, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcedn_frame_sched.md
Name: bcedn_frame_sched

Overview:
- Frame-level controller in front of the single encoder/decoder stage and its 512-bit input FIFO.
- Accepts one frame request at a time and issues the one-cycle start pulse to the engine.
- Gates host writes into the input FIFO so exactly one frame's worth of input beats enters.
- Counts result beats and the engine's completion flag, enforces a minimum idle gap between frames, and reports status and errors.

Parameters:
- IN_BEATS, 1024: 512-bit input words per frame.
- OUT_BEATS, 1024: 512-bit result words expected per frame.
- CNT_W, 16: width of the beat counters; must satisfy 2^CNT_W > max(IN_BEATS, OUT_BEATS).
- GAP_CYC, 4: minimum idle cycles after a frame completes before the next start; must be at least 1.
- FRM_W, 16: width of the completed-frame counter.
- TIMEOUT, 65535: watchdog stall limit in cycles; used only when the watchdog macro is defined.

Ports:
- clk, input, 1: single clock.
- rst, input, 1: asynchronous, active-low reset.
- frame_req, input, 1: host requests a frame.
- frame_ack, output, 1: one-cycle pulse when the request is accepted.
- host_in_valid, input, 1: host has an input word available.
- host_in_ready, output, 1: the word is taken this cycle.
- fifo_wfull, input, 1: input FIFO almost-full flag.
- fifo_winc, output, 1: input FIFO write enable.
- eng_start, output, 1: one-cycle start pulse to the engine.
- eng_done, input, 1: engine completion pulse (tg_next).
- eng_out_en, input, 1: engine result-beat strobe.
- busy, output, 1: high whenever the state is not IDLE.
- in_cnt, output, CNT_W: input beats accepted in the current frame.
- out_cnt, output, CNT_W: result beats seen in the current frame.
- frame_cnt, output, FRM_W: frames completed since reset.
- err_overrun, output, 1: sticky result-overrun error.
- err_timeout, output, 1: sticky watchdog error.

Behaviour:
- Reset (rst=0, asynchronous):
  - State is IDLE.
  - All outputs are 0, all counters are 0, both error flags are cleared.
- IDLE:
  - When frame_req=1, the next edge asserts frame_ack for one cycle, clears in_cnt, out_cnt and done_seen, and moves to START.
  - frame_req is level-sensitive. A request held high across frame completion starts the next frame after GAP.
- START:
  - eng_start=1 for exactly one cycle, then RUN.
  - Latency from accepted frame_req to eng_start is 2 cycles.
- RUN:
  - fifo_winc = host_in_ready = host_in_valid & ~fifo_wfull & (in_cnt < IN_BEATS). This is combinational, with no added latency.
  - in_cnt increments on each fifo_winc.
  - out_cnt increments on each eng_out_en while out_cnt < OUT_BEATS.
  - An eng_out_en with out_cnt == OUT_BEATS sets err_overrun (sticky) and does not increment out_cnt.
  - eng_done sets the done_seen flag. If eng_done arrives in START, it is also captured.
  - Exit to GAP when in_cnt == IN_BEATS, out_cnt == OUT_BEATS and done_seen all hold. Simultaneous final beat and eng_done in one cycle counts both and exits on the next cycle.
- GAP:
  - Counts GAP_CYC cycles.
  - On entry, frame_cnt increments once; it wraps modulo 2^FRM_W.
  - Then moves to IDLE.
- Outside RUN:
  - host_in_ready = fifo_winc = 0.
  - eng_out_en is counted as an overrun (err_overrun sets); eng_done is ignored.
- Counter saturation: in_cnt and out_cnt never exceed their limits. Counters hold their values in IDLE and GAP until the next accepted request.
- Reset mid-frame returns to IDLE immediately. The FIFO shares the same reset, so no partial frame persists.
- An error flag clears only on reset. Errors do not stall the sequencer.

Optional Feature:
- Macro: BCEDN_FRAME_SCHED_WATCHDOG_EN.
- Defined:
  - A stall counter in RUN clears on any fifo_winc, eng_out_en or eng_done, and increments otherwise.
  - On reaching TIMEOUT: err_timeout sets (sticky) and the state forces to GAP without incrementing frame_cnt.
- Undefined:
  - No stall counter exists, err_timeout is tied to 0, and the TIMEOUT parameter is unused.

Decomposition:
- Shared package bcedn_sched_pkg holds:
  - the state enum (IDLE, START, RUN, GAP);
  - the default IN_BEATS/OUT_BEATS constants for the EC_4 configuration;
  - the bus-width localparam for 512-bit data.
- One sub-module, bcedn_beat_counter: a saturating up-counter with clear, enable and limit, plus a hit flag.
  - It is instantiated twice, for in_cnt and out_cnt.
- FSM, gap counter and error logic live in the top.

Test Plan:
- Nominal frame, IN_BEATS=OUT_BEATS=8, GAP_CYC=4:
  - Stimulus: pulse frame_req, stream 8 words, 8 out_en beats, then eng_done.
  - Response: frame_ack at cycle 1, eng_start at cycle 2, exactly 8 fifo_winc, frame_cnt=1, busy low 4 cycles after exit.
- Backpressure: fifo_wfull=1 for cycles 5-9 while host_in_valid=1.
  - Response: fifo_winc=0 during those cycles, in_cnt frozen, and the frame still completes with in_cnt=8.
- Host overrun: host_in_valid held high for 12 cycles.
  - Response: fifo_winc only 8 times, host_in_ready=0 after the 8th word.
- Result overrun: 9 eng_out_en beats in RUN.
  - Response: err_overrun=1 from the 9th beat onward, out_cnt=8.
- Async reset mid-RUN (in_cnt=3):
  - Response: outputs 0 immediately without a clock, state IDLE. A following frame_req runs normally.
- Watchdog with the macro defined and TIMEOUT=16: no beats after eng_start.
  - Response: err_timeout=1 after 16 RUN cycles, state goes through GAP to IDLE, frame_cnt unchanged.
